// File: rtl/regular_fuzzifier_multi_pkg.sv
// Shared types and sizing helpers for the multi-channel regular fuzzifier.
// REGULAR_FUZZ_INTERP_EN selects interpolated lookup (adds one lookup cycle).
package regular_fuzzy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_VALID  = 2'd2
    } fuzz_state_e;

    localparam int DEF_N_CH       = 2;
    localparam int DEF_INPUT_BITS = 10;
    localparam int DEF_LUT_DEPTH  = 16;
    localparam int DEF_MEMB_BITS  = 7;

`ifdef REGULAR_FUZZ_INTERP_EN
    localparam int LOOKUP_CYCLES = 2;
`else
    localparam int LOOKUP_CYCLES = 1;
`endif

    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int frac_bits(input int in_bits, input int depth);
        return in_bits - $clog2(depth);
    endfunction

endpackage

// File: rtl/regular_fuzzifier_multi_if.sv
// Serial input, LUT and result handshake bundle of the fuzzifier.
interface regular_fuzzifier_multi_if
    import regular_fuzzy_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int INPUT_BITS = DEF_INPUT_BITS,
    parameter int LUT_DEPTH  = DEF_LUT_DEPTH,
    parameter int MEMB_BITS  = DEF_MEMB_BITS
);
    logic                              start;
    logic [N_CH-1:0]                   ser_in;
    logic [N_CH*LUT_DEPTH*MEMB_BITS-1:0] lut_table;
    logic                              out_ready;
    logic                              out_valid;
    logic [N_CH*MEMB_BITS-1:0]         out_result;
    logic [N_CH*INPUT_BITS-1:0]        out_sample;
    logic                              busy;
    logic                              overrun;

    modport master (
        output start, ser_in, lut_table, out_ready,
        input  out_valid, out_result, out_sample, busy, overrun
    );

    modport slave (
        input  start, ser_in, lut_table, out_ready,
        output out_valid, out_result, out_sample, busy, overrun
    );
endinterface

// File: rtl/regular_fuzzifier_multi_lut.sv
// One channel's membership lookup: step mux, or with REGULAR_FUZZ_INTERP_EN a
// registered entry/slope stage followed by linear interpolation.
module fuzzy_lut_lookup #(
    parameter int LUT_DEPTH = 16,
    parameter int MEMB_BITS = 7,
`ifdef REGULAR_FUZZ_INTERP_EN
    parameter int FRAC_BITS = 6,
`endif
    parameter int ADDR_BITS = 4
) (
`ifdef REGULAR_FUZZ_INTERP_EN
    input  logic                           clock,
    input  logic [FRAC_BITS-1:0]           frac_i,
`endif
    input  logic [LUT_DEPTH*MEMB_BITS-1:0] lut_i,
    input  logic [ADDR_BITS-1:0]           addr_i,
    output logic [MEMB_BITS-1:0]           result_o
);

    logic [MEMB_BITS-1:0] e_a;
    assign e_a = lut_i[int'(addr_i)*MEMB_BITS +: MEMB_BITS];

`ifdef REGULAR_FUZZ_INTERP_EN
    localparam int PW = MEMB_BITS + FRAC_BITS + 2;

    logic [ADDR_BITS-1:0]        addr_nx;
    logic [MEMB_BITS-1:0]        e_b;
    logic signed [MEMB_BITS:0]   d;
    logic [MEMB_BITS-1:0]        e_a_q;
    logic signed [MEMB_BITS:0]   d_q;
    logic [FRAC_BITS-1:0]        frac_q;
    logic signed [PW-1:0]        d_ext, f_ext, prod, sum;

    // Last entry interpolates against itself, i.e. flat slope.
    assign addr_nx = (int'(addr_i) == LUT_DEPTH-1) ? addr_i : addr_i + 1'b1;
    assign e_b     = lut_i[int'(addr_nx)*MEMB_BITS +: MEMB_BITS];
    assign d       = $signed({1'b0, e_b}) - $signed({1'b0, e_a});

    always_ff @(posedge clock) begin
        e_a_q  <= e_a;
        d_q    <= d;
        frac_q <= frac_i;
    end

    always_comb begin
        d_ext    = PW'(d_q);
        f_ext    = PW'($signed({1'b0, frac_q}));
        prod     = d_ext * f_ext;
        sum      = PW'($signed({1'b0, e_a_q})) + (prod >>> FRAC_BITS);
        result_o = MEMB_BITS'(sum);
    end
`else
    assign result_o = e_a;
`endif

endmodule

// File: rtl/regular_fuzzifier_multi.sv
// Multi-channel serial fuzzifier: deserialise N_CH MSB-first frames, look up membership
// degrees, present them on a valid/ready output with overrun detection (see REGULAR_FUZZ_INTERP_EN).
module regular_fuzzifier_multi
    import regular_fuzzy_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int INPUT_BITS = DEF_INPUT_BITS,
    parameter int LUT_DEPTH  = DEF_LUT_DEPTH,
    parameter int MEMB_BITS  = DEF_MEMB_BITS
) (
    input logic                      clock,
    input logic                      reset,
    regular_fuzzifier_multi_if.slave fz
);

    localparam int ADDR_BITS = addr_bits(LUT_DEPTH);
    localparam int FRAC_BITS = frac_bits(INPUT_BITS, LUT_DEPTH);
    localparam int CNT_W     = $clog2(INPUT_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INPUT_BITS - 1);
    localparam logic             LK_LAST  = 1'(LOOKUP_CYCLES - 1);

    fuzz_state_e state_q, state_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [N_CH-1:0][INPUT_BITS-1:0]       shift_q, shift_d;
    logic [N_CH-1:0][INPUT_BITS-1:0]       hold_q, hold_d;
    logic                                  pending_q, pending_d;
    logic                                  lk_cnt_q, lk_cnt_d;
    logic [N_CH*MEMB_BITS-1:0]             result_q, result_d;
    logic [N_CH*INPUT_BITS-1:0]            sample_q, sample_d;
    logic                                  overrun_q, overrun_d;
    logic [N_CH-1:0][MEMB_BITS-1:0]        deg;
    logic                                  frame_done, occupied, out_valid;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        fuzzy_lut_lookup #(
            .LUT_DEPTH (LUT_DEPTH),
            .MEMB_BITS (MEMB_BITS),
`ifdef REGULAR_FUZZ_INTERP_EN
            .FRAC_BITS (FRAC_BITS),
`endif
            .ADDR_BITS (ADDR_BITS)
        ) u_lut (
`ifdef REGULAR_FUZZ_INTERP_EN
            .clock    (clock),
            .frac_i   (hold_q[c][FRAC_BITS-1:0]),
`endif
            .lut_i    (fz.lut_table[c*LUT_DEPTH*MEMB_BITS +: LUT_DEPTH*MEMB_BITS]),
            .addr_i   (hold_q[c][INPUT_BITS-1 -: ADDR_BITS]),
            .result_o (deg[c])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_LAST;
            shift_q   <= '0;
            hold_q    <= '0;
            pending_q <= 1'b0;
            lk_cnt_q  <= 1'b0;
            result_q  <= '0;
            sample_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            lk_cnt_q  <= lk_cnt_d;
            result_q  <= result_d;
            sample_q  <= sample_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        pending_d  = pending_q;
        lk_cnt_d   = lk_cnt_q;
        result_d   = result_q;
        sample_d   = sample_q;
        overrun_d  = overrun_q;
        frame_done = 1'b0;

        out_valid = (state_q == ST_VALID);
        occupied  = pending_q || (out_valid && !fz.out_ready);

        if (fz.start) begin
            for (int c = 0; c < N_CH; c++) begin
                shift_d[c] = {shift_q[c][INPUT_BITS-2:0], fz.ser_in[c]};
            end
            if (cnt_q == '0) begin
                frame_done = 1'b1;
                cnt_d      = CNT_LAST;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // A completed frame may only enter the hold register if nothing is waiting for it.
        if (frame_done) begin
            if (occupied) begin
                overrun_d = 1'b1;
            end else begin
                hold_d    = shift_d;
                pending_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    lk_cnt_d  = 1'b0;
                    state_d   = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lk_cnt_q == LK_LAST) begin
                    result_d = deg;
                    sample_d = hold_q;
                    state_d  = ST_VALID;
                end else begin
                    lk_cnt_d = lk_cnt_q + 1'b1;
                end
            end
            ST_VALID: begin
                if (fz.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fz.out_valid  = (state_q == ST_VALID);
    assign fz.out_result = result_q;
    assign fz.out_sample = sample_q;
    assign fz.overrun    = overrun_q;
    assign fz.busy       = (cnt_q != CNT_LAST) | pending_q | (state_q == ST_LOOKUP);

endmodule

// File: tb/tb_regular_fuzzifier_multi.sv
// Directed and random bench for regular_fuzzifier_multi against a floor-arithmetic reference.
module tb_regular_fuzzifier_multi;
    import regular_fuzzy_pkg::*;

    localparam int NC = 2;
    localparam int IB = 10;
    localparam int LD = 16;
    localparam int MB = 7;
    localparam int FB = IB - $clog2(LD);
`ifdef REGULAR_FUZZ_INTERP_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   lut_arr [NC][LD];

    always #5 clock = ~clock;

    regular_fuzzifier_multi_if #(.N_CH(NC), .INPUT_BITS(IB), .LUT_DEPTH(LD), .MEMB_BITS(MB)) fz_if ();

    regular_fuzzifier_multi #(.N_CH(NC), .INPUT_BITS(IB), .LUT_DEPTH(LD), .MEMB_BITS(MB)) dut (
        .clock (clock),
        .reset (reset),
        .fz    (fz_if.slave)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_deg(input int c, input int s);
        int a, f, ea, eb, t, sh;
        a  = s / (1 << FB);
        f  = s % (1 << FB);
        ea = lut_arr[c][a];
`ifdef REGULAR_FUZZ_INTERP_EN
        eb = (a == LD-1) ? ea : lut_arr[c][a+1];
        t  = (eb - ea) * f;
        sh = (t >= 0) ? t / (1 << FB) : -((-t + (1 << FB) - 1) / (1 << FB));
        return ea + sh;
`else
        eb = 0; t = 0; sh = 0;
        return ea;
`endif
    endfunction

    function automatic logic [63:0] exp_res(input int s0, input int s1);
        logic [13:0] r;
        r[6:0]  = 7'(ref_deg(0, s0));
        r[13:7] = 7'(ref_deg(1, s1));
        return 64'(r);
    endfunction

    task automatic load_lut();
        for (int c = 0; c < NC; c++)
            for (int e = 0; e < LD; e++)
                fz_if.lut_table[(c*LD+e)*MB +: MB] = 7'(lut_arr[c][e]);
    endtask

    // Sends one frame MSB first; optional stall after bit index stall_at.
    task automatic send_frame(input logic [9:0] s0, input logic [9:0] s1, input int stall_at,
                              input int stall_len, input bit ready_at_last);
        for (int b = 0; b < IB; b++) begin
            fz_if.start  = 1'b1;
            fz_if.ser_in = {s1[9-b], s0[9-b]};
            if (b == IB-1 && ready_at_last) fz_if.out_ready = 1'b1;
            step();
            if (b == stall_at) begin
                fz_if.start = 1'b0;
                repeat (stall_len) step();
                chk("busy_stall", 64'(fz_if.busy), 64'd1);
            end
        end
        fz_if.start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!fz_if.out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(LAT));
    endtask

    task automatic frame_check(input string tag, input logic [9:0] s0, input logic [9:0] s1,
                               input int stall_at, input int stall_len);
        send_frame(s0, s1, stall_at, stall_len, 1'b0);
        wait_valid(tag);
        chk({tag, "_result"}, 64'(fz_if.out_result), exp_res(s0, s1));
        chk({tag, "_sample"}, 64'(fz_if.out_sample), 64'({s1, s0}));
        step();
        chk({tag, "_valid_drop"}, 64'(fz_if.out_valid), 64'd0);
    endtask

    initial begin
        logic [9:0] a0, a1, b0, b1;
        int st;

        for (int c = 0; c < NC; c++)
            for (int e = 0; e < LD; e++)
                lut_arr[c][e] = int'($urandom_range(0, 127));
        lut_arr[0][8] = 100;
        lut_arr[0][9] = 40;
        lut_arr[1][0] = 5;
        load_lut();

        reset = 1'b1;
        fz_if.start = 1'b0;
        fz_if.ser_in = '0;
        fz_if.out_ready = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        chk("rst_valid", 64'(fz_if.out_valid), 64'd0);
        chk("rst_overrun", 64'(fz_if.overrun), 64'd0);
        chk("rst_busy", 64'(fz_if.busy), 64'd0);
        chk("rst_result", 64'(fz_if.out_result), 64'd0);
        chk("rst_sample", 64'(fz_if.out_sample), 64'd0);

        frame_check("basic", 10'd512, 10'd0, -1, 0);
        chk("basic_const", 64'(fz_if.out_sample), 64'({10'd0, 10'd512}));
        send_frame(10'd512, 10'd0, -1, 0, 1'b0);
        wait_valid("basic2");
        chk("basic_result_const", 64'(fz_if.out_result), 64'({7'd5, 7'd100}));
        step();

        frame_check("stall", 10'd512, 10'd0, 4, 3);

        send_frame(10'd544, 10'd0, -1, 0, 1'b0);
        wait_valid("interp");
`ifdef REGULAR_FUZZ_INTERP_EN
        chk("interp_ch0", 64'(fz_if.out_result[6:0]), 64'd70);
`else
        chk("interp_ch0", 64'(fz_if.out_result[6:0]), 64'd100);
`endif
        step();
        send_frame(10'd1023, 10'd0, -1, 0, 1'b0);
        wait_valid("top");
        chk("top_ch0", 64'(fz_if.out_result[6:0]), 64'(lut_arr[0][15]));
        step();

        for (int i = 0; i < 8; i++) begin
            a0 = 10'($urandom);
            a1 = 10'($urandom);
            st = int'($urandom_range(0, 11));
            if (st > 8) st = -1;
            frame_check("rand", a0, a1, st, int'($urandom_range(1, 4)));
        end

        // Completion on the handshake edge is accepted without overrun.
        a0 = 10'($urandom); a1 = 10'($urandom);
        b0 = 10'($urandom); b1 = 10'($urandom);
        fz_if.out_ready = 1'b0;
        send_frame(a0, a1, -1, 0, 1'b0);
        wait_valid("hs_first");
        send_frame(b0, b1, -1, 0, 1'b1);
        chk("hs_valid_low", 64'(fz_if.out_valid), 64'd0);
        chk("hs_no_overrun", 64'(fz_if.overrun), 64'd0);
        wait_valid("hs_second");
        chk("hs_result", 64'(fz_if.out_result), exp_res(b0, b1));
        chk("hs_sample", 64'(fz_if.out_sample), 64'({b1, b0}));
        step();

        // Held result with consumer stalled; second frame must be dropped.
        fz_if.out_ready = 1'b0;
        send_frame(a0, a1, -1, 0, 1'b0);
        wait_valid("ovr_first");
        chk("ovr_before", 64'(fz_if.overrun), 64'd0);
        send_frame(b0, b1, -1, 0, 1'b0);
        chk("ovr_set", 64'(fz_if.overrun), 64'd1);
        chk("ovr_valid_held", 64'(fz_if.out_valid), 64'd1);
        chk("ovr_sample_held", 64'(fz_if.out_sample), 64'({a1, a0}));
        chk("ovr_result_held", 64'(fz_if.out_result), exp_res(a0, a1));
        fz_if.out_ready = 1'b1;
        step();
        chk("ovr_accept", 64'(fz_if.out_valid), 64'd0);
        chk("ovr_idle_busy", 64'(fz_if.busy), 64'd0);
        chk("ovr_sticky", 64'(fz_if.overrun), 64'd1);
        repeat (3) step();
        chk("ovr_no_late_valid", 64'(fz_if.out_valid), 64'd0);

        // Reset mid-frame: partial bits discarded.
        for (int b = 0; b < 5; b++) begin
            fz_if.start = 1'b1;
            fz_if.ser_in = 2'b11;
            step();
        end
        fz_if.start = 1'b0;
        chk("mid_busy", 64'(fz_if.busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", 64'(fz_if.busy), 64'd0);
        chk("mid_rst_overrun", 64'(fz_if.overrun), 64'd0);
        send_frame(10'd512, 10'd0, -1, 0, 1'b0);
        wait_valid("mid");
        chk("mid_result", 64'(fz_if.out_result), 64'({7'd5, 7'd100}));
        chk("mid_overrun", 64'(fz_if.overrun), 64'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
